fir_tdm_sequencer: RTL and testbench

- Sequencer for the time-shared symmetric FIR datapath: one multiplier bank is reused TDM_FACTOR times per input sample.
- Generates, in lock-step with sam_clk_en:
  - the phase index
  - the coefficient-ROM address, using a coefficient bank latched once per sample
  - accumulator clear/enable/capture strobes
  - the output-register load strobe, delayed by the adder-tree latency
- Sits between the sample-clock-enable generator and the multiplier/accumulator/adder-tree datapath.
- Detects and reports sample-enable misalignment.

---
 rtl/fir_tdm_pkg.sv | 21 ++
 rtl/fir_tdm_sequencer_delay.sv | 36 +++
 rtl/fir_tdm_sequencer.sv | 124 ++++++++++++
 tb/tb_fir_tdm_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_tdm_pkg.sv
// Shared definitions for the time-shared symmetric FIR sequencer.
// Defaults, state encoding and coefficient-bank switch encodings.
package fir_tdm_pkg;

    localparam int TDM_FACTOR_D = 4;
    localparam int PHASE_W_D    = 2;
    localparam int BANK_W_D     = 2;
    localparam int PIPE_LAT_D   = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_t;

    // Filter-selection switch settings as seen on bank_sel_in
    localparam logic [BANK_W_D-1:0] BANK_LOWPASS  = 2'b00;
    localparam logic [BANK_W_D-1:0] BANK_BANDPASS = 2'b01;
    localparam logic [BANK_W_D-1:0] BANK_HIGHPASS = 2'b10;
    localparam logic [BANK_W_D-1:0] BANK_BYPASS   = 2'b11;

endpackage

// File: rtl/fir_tdm_sequencer_delay.sv
// Fixed-depth 1-bit strobe delay line with asynchronous reset.
// Carries acc_capture through the adder-tree latency to become y_load.
module strobe_delay_line #(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    generate
        if (DEPTH == 1) begin : g_single
            logic r_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_q <= 1'b0;
                end else begin
                    r_q <= i_d;
                end
            end
            assign o_q = r_q;
        end else begin : g_chain
            logic [DEPTH-1:0] r_sh;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sh <= '0;
                end else begin
                    r_sh <= {r_sh[DEPTH-2:0], i_d};
                end
            end
            assign o_q = r_sh[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fir_tdm_sequencer.sv
// TDM phase/strobe sequencer for the shared-multiplier FIR datapath.
// Define TDM_SEQ_STATUS_EN to add err_count/sample_count status outputs.
module fir_tdm_sequencer
    import fir_tdm_pkg::*;
#(
    parameter int TDM_FACTOR = TDM_FACTOR_D,
    parameter int PHASE_W    = PHASE_W_D,
    parameter int BANK_W     = BANK_W_D,
    parameter int PIPE_LAT   = PIPE_LAT_D
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sam_clk_en,
    input  logic [BANK_W-1:0]         bank_sel_in,
    output logic [PHASE_W-1:0]        phase,
    output logic [BANK_W+PHASE_W-1:0] coef_addr,
    output logic                      acc_clr,
    output logic                      acc_en,
    output logic                      acc_capture,
    output logic                      y_load,
    output logic                      running,
    output logic                      sync_err
`ifdef TDM_SEQ_STATUS_EN
    ,
    output logic [7:0]                err_count,
    output logic [15:0]               sample_count
`endif
);

    localparam logic [PHASE_W-1:0] LAST = PHASE_W'(TDM_FACTOR - 1);

    seq_state_t         r_state;
    logic [PHASE_W-1:0] r_phase;
    logic [BANK_W-1:0]  r_bank;
    logic               r_hold;
    logic               r_running;
    logic               r_sync_err;

    logic w_last;
    logic w_capture;

    assign w_last = (r_phase == LAST);

    // r_hold marks every cycle spent parked on the last phase after the
    // first one; the rising edge of r_hold is the late-enable report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_phase    <= '0;
            r_bank     <= '0;
            r_hold     <= 1'b0;
            r_running  <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_sync_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (sam_clk_en) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                        r_phase   <= '0;
                        r_bank    <= bank_sel_in;
                        r_hold    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (sam_clk_en) begin
                        r_phase    <= '0;
                        r_bank     <= bank_sel_in;
                        r_hold     <= 1'b0;
                        r_sync_err <= !w_last;
                    end else if (!w_last) begin
                        r_phase <= r_phase + PHASE_W'(1);
                    end else begin
                        r_hold     <= 1'b1;
                        r_sync_err <= !r_hold;
                    end
                end
            endcase
        end
    end

    assign w_capture = r_running & w_last & ~r_hold;

    assign phase       = r_phase;
    assign coef_addr   = {r_bank, r_phase};
    assign running     = r_running;
    assign sync_err    = r_sync_err;
    assign acc_en      = r_running & ~r_hold;
    assign acc_clr     = r_running & (r_phase == '0);
    assign acc_capture = w_capture;

    strobe_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_y_load_dly (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_capture),
        .o_q   (y_load)
    );

`ifdef TDM_SEQ_STATUS_EN
    logic [7:0]  r_err_count;
    logic [15:0] r_sample_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count    <= '0;
            r_sample_count <= '0;
        end else begin
            if (r_sync_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
            if (w_capture) begin
                r_sample_count <= r_sample_count + 16'd1;
            end
        end
    end

    assign err_count    = r_err_count;
    assign sample_count = r_sample_count;
`endif

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// Scoreboard bench for fir_tdm_sequencer with directed per-cycle vectors.
// With TDM_SEQ_STATUS_EN defined the status counters are checked too.
module tb_fir_tdm_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sam_clk_en = 1'b0;
    logic [1:0] bank_sel_in = 2'b01;
    logic [1:0] phase;
    logic [3:0] coef_addr;
    logic       acc_clr;
    logic       acc_en;
    logic       acc_capture;
    logic       y_load;
    logic       running;
    logic       sync_err;
`ifdef TDM_SEQ_STATUS_EN
    logic [7:0]  err_count;
    logic [15:0] sample_count;
`endif

    fir_tdm_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .sam_clk_en   (sam_clk_en),
        .bank_sel_in  (bank_sel_in),
        .phase        (phase),
        .coef_addr    (coef_addr),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .acc_capture  (acc_capture),
        .y_load       (y_load),
        .running      (running),
        .sync_err     (sync_err)
`ifdef TDM_SEQ_STATUS_EN
        ,
        .err_count    (err_count),
        .sample_count (sample_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ph;
        logic [3:0] ad;
        logic       clr;
        logic       aen;
        logic       cap;
        logic       yl;
        logic       run;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Drive one cycle of stimulus and queue the outputs expected in it
    task automatic row(input logic rst, input logic en, input logic [1:0] bk,
                       input logic [1:0] ph, input logic [3:0] ad,
                       input logic clr, input logic aen, input logic cap,
                       input logic yl, input logic run, input logic err);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        sam_clk_en  = en;
        bank_sel_in = bk;
        e = '{ph, ad, clr, aen, cap, yl, run, err};
        q.push_back(e);
    endtask

    task automatic zrow(input logic rst, input logic en, input logic [1:0] bk);
        row(rst, en, bk, 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                a = '{phase, coef_addr, acc_clr, acc_en, acc_capture,
                      y_load, running, sync_err};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL row%0d: got ph=%0d addr=%0d clr=%b en=%b cap=%b yl=%b run=%b err=%b, want ph=%0d addr=%0d clr=%b en=%b cap=%b yl=%b run=%b err=%b",
                             cyc, a.ph, a.ad, a.clr, a.aen, a.cap, a.yl, a.run, a.err,
                             e.ph, e.ad, e.clr, e.aen, e.cap, e.yl, e.run, e.err);
                end
                cyc++;
            end
        end
    end

`ifdef TDM_SEQ_STATUS_EN
    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask
`endif

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // reset, then idle; enable in IDLE is not an error
        zrow(1, 0, 1);
        zrow(1, 0, 1);
        zrow(0, 0, 1);
        zrow(0, 1, 1);
        // nominal period, bank 01
        row(0, 0, 1, 0,  4, 1, 1, 0, 0, 1, 0);
        row(0, 0, 1, 1,  5, 0, 1, 0, 0, 1, 0);
        row(0, 0, 1, 2,  6, 0, 1, 0, 0, 1, 0);
        row(0, 1, 1, 3,  7, 0, 1, 1, 0, 1, 0);
        // bank switch at phase 1 takes effect next sample
        row(0, 0, 1, 0,  4, 1, 1, 0, 0, 1, 0);
        row(0, 0, 2, 1,  5, 0, 1, 0, 0, 1, 0);
        row(0, 0, 2, 2,  6, 0, 1, 0, 0, 1, 0);
        row(0, 1, 2, 3,  7, 0, 1, 1, 0, 1, 0);
        row(0, 0, 2, 0,  8, 1, 1, 0, 1, 1, 0);
        row(0, 0, 2, 1,  9, 0, 1, 0, 0, 1, 0);
        row(0, 0, 2, 2, 10, 0, 1, 0, 0, 1, 0);
        row(0, 1, 2, 3, 11, 0, 1, 1, 0, 1, 0);
        // early enable at phase 1
        row(0, 0, 2, 0,  8, 1, 1, 0, 1, 1, 0);
        row(0, 1, 2, 1,  9, 0, 1, 0, 0, 1, 0);
        row(0, 0, 2, 0,  8, 1, 1, 0, 0, 1, 1);
        row(0, 0, 2, 1,  9, 0, 1, 0, 0, 1, 0);
        row(0, 0, 2, 2, 10, 0, 1, 0, 1, 1, 0);
        row(0, 1, 2, 3, 11, 0, 1, 1, 0, 1, 0);
        row(0, 0, 2, 0,  8, 1, 1, 0, 0, 1, 0);
        // late enable: 6 clk period
        row(0, 0, 2, 1,  9, 0, 1, 0, 0, 1, 0);
        row(0, 0, 2, 2, 10, 0, 1, 0, 0, 1, 0);
        row(0, 0, 2, 3, 11, 0, 1, 1, 0, 1, 0);
        row(0, 0, 2, 3, 11, 0, 0, 0, 1, 1, 1);
        row(0, 1, 2, 3, 11, 0, 0, 0, 0, 1, 0);
        row(0, 0, 2, 0,  8, 1, 1, 0, 0, 1, 0);
        row(0, 0, 2, 1,  9, 0, 1, 0, 0, 1, 0);
        row(0, 0, 2, 2, 10, 0, 1, 0, 1, 1, 0);
        row(0, 1, 2, 3, 11, 0, 1, 1, 0, 1, 0);
        row(0, 0, 2, 0,  8, 1, 1, 0, 0, 1, 0);
        row(0, 0, 2, 1,  9, 0, 1, 0, 0, 1, 0);
        // reset at phase 2 with a y_load pending
        zrow(1, 0, 2);
        zrow(1, 0, 2);
        zrow(0, 0, 2);
        zrow(0, 0, 2);
        zrow(0, 0, 2);
        zrow(0, 0, 2);
        zrow(0, 1, 3);
        row(0, 0, 3, 0, 12, 1, 1, 0, 0, 1, 0);
        row(0, 0, 3, 1, 13, 0, 1, 0, 0, 1, 0);
        row(0, 0, 3, 2, 14, 0, 1, 0, 0, 1, 0);
        row(0, 1, 3, 3, 15, 0, 1, 1, 0, 1, 0);
        row(0, 0, 3, 0, 12, 1, 1, 0, 0, 1, 0);
        row(0, 0, 3, 1, 13, 0, 1, 0, 0, 1, 0);
        row(0, 0, 3, 2, 14, 0, 1, 0, 0, 1, 0);
        // longer late hold: late reported only once
        row(0, 0, 3, 3, 15, 0, 1, 1, 0, 1, 0);
        row(0, 0, 3, 3, 15, 0, 0, 0, 1, 1, 1);
        row(0, 0, 3, 3, 15, 0, 0, 0, 0, 1, 0);
        row(0, 1, 3, 3, 15, 0, 0, 0, 0, 1, 0);
        row(0, 0, 3, 0, 12, 1, 1, 0, 0, 1, 0);
        row(0, 0, 3, 1, 13, 0, 1, 0, 1, 1, 0);
        row(0, 0, 3, 2, 14, 0, 1, 0, 0, 1, 0);
        row(0, 0, 3, 3, 15, 0, 1, 1, 0, 1, 0);
        row(0, 0, 3, 3, 15, 0, 0, 0, 0, 1, 1);
        row(0, 0, 3, 3, 15, 0, 0, 0, 0, 1, 0);
        row(0, 0, 3, 3, 15, 0, 0, 0, 0, 1, 0);
        row(0, 0, 3, 3, 15, 0, 0, 0, 0, 1, 0);
        row(0, 0, 3, 3, 15, 0, 0, 0, 1, 1, 0);
        @(posedge clk);
        @(posedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending rows want 0", q.size());
        end

`ifdef TDM_SEQ_STATUS_EN
        #1;
        reset      = 1'b1;
        sam_clk_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("err_count_reset", int'(err_count), 0);
        chk("sample_count_reset", int'(sample_count), 0);
        for (int i = 0; i < 301; i++) begin
            @(posedge clk);
            #1;
            sam_clk_en = 1'b1;
            @(posedge clk);
            #1;
            sam_clk_en = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("err_count_sat", int'(err_count), 255);
        chk("sample_count_none", int'(sample_count), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("err_count_hold", int'(err_count), 255);
        chk("sample_count_one", int'(sample_count), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
